approx_mul_err_sweeper: RTL and testbench
=========================================

// Module: approx_mul_err_sweeper
// PURPOSE
//  Exhaustive stimulus driver and error checker for a combinational approximate multiplier
//  (e.g. a 2x2 SOP-approximated mul, 4 in / 4 out). Drives every input vector into the
//  multiplier, captures its product, compares it to the exact product and accumulates error
//  statistics against the error threshold ET. Sits directly upstream (stim) and downstream (approx).
// PARAMETERS
//  IN_W     4  total multiplier input bits; operands a=stim[IN_W/2-1:0], b=stim[IN_W-1:IN_W/2]
//  ET       8  error threshold; an absolute error > ET is a violation
//  DUT_LAT  0  cycles from stim change to valid approx (0 = purely combinational DUT)
//  localparam OUT_W = IN_W, N_VEC = 2**IN_W, SUM_W = 2*IN_W
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous, active-high reset
//  start          in   1      request a sweep; sampled in IDLE or DONE only
//  stim           out  IN_W   registered vector driven to multiplier inputs in0..in(IN_W-1)
//  approx         in   OUT_W  multiplier outputs out0..out(OUT_W-1), bit i = out_i
//  busy           out  1      high in SWEEP and DRAIN
//  done           out  1      level, high in DONE until next accepted start or reset
//  max_err        out  OUT_W  largest |exact - approx| seen in current sweep
//  sum_err        out  SUM_W  sum of |exact - approx| over all vectors
//  fail_cnt       out  IN_W+1 number of vectors with error > ET
//  violation      out  1      max_err > ET (combinational from max_err)
//  first_fail_vld out  1      see CONFIGURATION
//  first_fail_vec out  IN_W   see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE; stim=0; busy=0; done=0; max_err=0; sum_err=0; fail_cnt=0; delay line cleared.
//  - FSM IDLE -> SWEEP on start (clears all accumulators same edge, stim=0).
//    SWEEP: stim increments by 1 per cycle; after stim=N_VEC-1 is driven -> DRAIN.
//    DRAIN: waits until last vector's comparison completes (DUT_LAT+1 cycles total) -> DONE.
//    DONE -> SWEEP on start (accumulators cleared). start in SWEEP/DRAIN is ignored.
//  - Comparison pipeline: exact = a*b (IN_W bits, unsigned) and a valid bit are delayed DUT_LAT
//    stages to align with approx; the compare stage is registered (one cycle). Net: vector v
//    driven at cycle t is accumulated on edge t+DUT_LAT+1.
//  - err = |exact - approx|, OUT_W bits unsigned. max_err = max(max_err, err);
//    sum_err += err (SUM_W never overflows: N_VEC*(2**OUT_W-1) < 2**SUM_W); fail_cnt += (err>ET).
//  - Only compare-valid cycles update accumulators; approx is don't-care otherwise.
//  - stim holds N_VEC-1 during DRAIN/DONE; returns to 0 on next accepted start.
//  - done asserts on the edge after the final accumulation; total start->done = N_VEC+DUT_LAT+1 cycles.
//  - Reset mid-sweep: immediate return to reset values; no partial results retained.
//  - Simultaneous start and rst: rst wins.
// CONFIGURATION
//  APPROX_FIRST_FAIL_EN defined: on the first compare in a sweep with err > ET,
//    first_fail_vld<=1 and first_fail_vec<=that vector (from the delayed pipeline); held until
//    next accepted start or reset. Later failures do not overwrite.
//  Not defined: first_fail_vld and first_fail_vec tied to 0; capture logic absent.
// TESTING
//  1 Exact multiplier in loopback (approx=a*b), DUT_LAT=0 -> done 17 cycles after start;
//    max_err=0, sum_err=0, fail_cnt=0, violation=0, first_fail_vld=0.
//  2 approx tied 0 -> sum_err=36, max_err=9, fail_cnt=1, violation=1;
//    with APPROX_FIRST_FAIL_EN: first_fail_vec=4'hF.
//  3 approx = (a*b)^1 -> max_err=1, sum_err=16, fail_cnt=0, violation=0.
//  4 Bench DUT model with 2-cycle delay, DUT_LAT=2 -> all errors 0; done 19 cycles after start.
//  5 start pulsed again at vector 5 of sweep -> ignored, results identical to scenario 2;
//    start in DONE re-runs and clears accumulators to 0 on accept edge.
//  6 rst asserted at vector 8 -> all outputs reset values immediately; new start gives full result.

Source files
------------

// File: rtl/approx_mul_err_sweeper.sv
// Exhaustive sweeper and error checker for a small combinational approximate multiplier.
// Optional first-failure capture is enabled by defining APPROX_FIRST_FAIL_EN.
module approx_mul_err_sweeper #(
  parameter int unsigned IN_W    = 4,
  parameter int unsigned ET      = 8,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IN_W-1:0]   stim,
  input  logic [IN_W-1:0]   approx,
  output logic              busy,
  output logic              done,
  output logic [IN_W-1:0]   max_err,
  output logic [2*IN_W-1:0] sum_err,
  output logic [IN_W:0]     fail_cnt,
  output logic              violation,
  output logic              first_fail_vld,
  output logic [IN_W-1:0]   first_fail_vec
);

  localparam int unsigned OUT_W = IN_W;
  localparam int unsigned N_VEC = 2 ** IN_W;
  localparam int unsigned SUM_W = 2 * IN_W;
  localparam int unsigned HALF  = IN_W / 2;
  localparam int unsigned CNT_W = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;

`ifdef APPROX_FIRST_FAIL_EN
  localparam int unsigned PAY_W = OUT_W + IN_W;
`else
  localparam int unsigned PAY_W = OUT_W;
`endif

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e             state_q;
  logic [IN_W-1:0]    stim_q;
  logic [CNT_W-1:0]   drain_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               accept;

  logic [OUT_W-1:0]   max_err_q;
  logic [SUM_W-1:0]   sum_err_q;
  logic [IN_W:0]      fail_cnt_q;

  logic               vld0;
  logic [OUT_W-1:0]   exact0;
  logic [PAY_W-1:0]   pay0;
  logic               vld_al;
  logic [PAY_W-1:0]   pay_al;
  logic [OUT_W-1:0]   exact_al;
  logic [OUT_W-1:0]   err;
  logic               err_over;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // Sweep control; busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      stim_q      <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StSweep;
            stim_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StSweep: begin
          if (stim_q == IN_W'(N_VEC - 1)) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
          end else begin
            stim_q <= stim_q + IN_W'(1);
          end
        end
        StDrain: begin
          if (drain_cnt_q == CNT_W'(DUT_LAT)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Exact reference for the vector currently on stim; valid only while sweeping.
  assign vld0   = (state_q == StSweep);
  assign exact0 = OUT_W'(stim_q[HALF-1:0]) * OUT_W'(stim_q[IN_W-1:HALF]);

`ifdef APPROX_FIRST_FAIL_EN
  assign pay0 = {stim_q, exact0};
`else
  assign pay0 = exact0;
`endif

  // Delay the reference so it lines up with the multiplier's output latency.
  generate
    if (DUT_LAT == 0) begin : g_no_delay
      assign vld_al = vld0;
      assign pay_al = pay0;
    end else begin : g_delay
      logic [DUT_LAT-1:0] vld_pipe;
      logic [PAY_W-1:0]   pay_pipe [DUT_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe <= '0;
          for (int i = 0; i < DUT_LAT; i++) begin
            pay_pipe[i] <= '0;
          end
        end else begin
          vld_pipe[0] <= vld0;
          pay_pipe[0] <= pay0;
          for (int i = 1; i < DUT_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            pay_pipe[i] <= pay_pipe[i-1];
          end
        end
      end

      assign vld_al = vld_pipe[DUT_LAT-1];
      assign pay_al = pay_pipe[DUT_LAT-1];
    end
  endgenerate

  assign exact_al = pay_al[OUT_W-1:0];
  assign err      = (exact_al >= approx) ? (exact_al - approx) : (approx - exact_al);
  assign err_over = 32'(err) > ET;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_err_q  <= '0;
      sum_err_q  <= '0;
      fail_cnt_q <= '0;
    end else if (accept) begin
      max_err_q  <= '0;
      sum_err_q  <= '0;
      fail_cnt_q <= '0;
    end else if (vld_al) begin
      if (err > max_err_q) begin
        max_err_q <= err;
      end
      sum_err_q <= sum_err_q + SUM_W'(err);
      if (err_over) begin
        fail_cnt_q <= fail_cnt_q + (IN_W + 1)'(1);
      end
    end
  end

`ifdef APPROX_FIRST_FAIL_EN
  logic            ff_vld_q;
  logic [IN_W-1:0] ff_vec_q;

  // Only the earliest failing vector of a sweep is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
    end else if (accept) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
    end else if (vld_al && err_over && !ff_vld_q) begin
      ff_vld_q <= 1'b1;
      ff_vec_q <= pay_al[PAY_W-1:OUT_W];
    end
  end

  assign first_fail_vld = ff_vld_q;
  assign first_fail_vec = ff_vec_q;
`else
  assign first_fail_vld = 1'b0;
  assign first_fail_vec = '0;
`endif

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign max_err   = max_err_q;
  assign sum_err   = sum_err_q;
  assign fail_cnt  = fail_cnt_q;
  assign violation = 32'(max_err_q) > ET;

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Bench for approx_mul_err_sweeper: lookup-table multiplier models, combinational and 2-cycle.
module tb_approx_mul_err_sweeper;

`ifdef APPROX_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  typedef logic [3:0] lut_t [16];
  typedef struct {
    int mx;
    int sm;
    int fl;
    int ffv;
    int ffvec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start0, start2;
  logic sel;
  int   checks   = 0;
  int   failures = 0;

  lut_t lut0, lut2;
  logic [3:0] stim0, stim2, approx0, approx2;
  logic [3:0] s2a = '0, s2b = '0;
  logic       busy0, done0, viol0, ffv0, busy2, done2, viol2, ffv2;
  logic [3:0] max0, ffvec0, max2, ffvec2;
  logic [7:0] sum0, sum2;
  logic [4:0] fcnt0, fcnt2;

  logic       o_busy, o_done, o_viol, o_ffv;
  logic [3:0] o_stim, o_max, o_ffvec;
  logic [7:0] o_sum;
  logic [4:0] o_fcnt;

  always #5 clk = ~clk;

  // Multiplier models: combinational table lookup, and the same with a 2-cycle delay.
  assign approx0 = lut0[stim0];
  always @(posedge clk) begin
    s2a <= stim2;
    s2b <= s2a;
  end
  assign approx2 = lut2[s2b];

  approx_mul_err_sweeper #(.IN_W(4), .ET(8), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stim(stim0), .approx(approx0),
    .busy(busy0), .done(done0), .max_err(max0), .sum_err(sum0), .fail_cnt(fcnt0),
    .violation(viol0), .first_fail_vld(ffv0), .first_fail_vec(ffvec0)
  );

  approx_mul_err_sweeper #(.IN_W(4), .ET(8), .DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stim(stim2), .approx(approx2),
    .busy(busy2), .done(done2), .max_err(max2), .sum_err(sum2), .fail_cnt(fcnt2),
    .violation(viol2), .first_fail_vld(ffv2), .first_fail_vec(ffvec2)
  );

  assign o_busy  = sel ? busy2  : busy0;
  assign o_done  = sel ? done2  : done0;
  assign o_viol  = sel ? viol2  : viol0;
  assign o_ffv   = sel ? ffv2   : ffv0;
  assign o_stim  = sel ? stim2  : stim0;
  assign o_max   = sel ? max2   : max0;
  assign o_ffvec = sel ? ffvec2 : ffvec0;
  assign o_sum   = sel ? sum2   : sum0;
  assign o_fcnt  = sel ? fcnt2  : fcnt0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference statistics straight from the definition: walk every (a, b) pair.
  function automatic exp_t model(input lut_t l);
    exp_t r;
    int   v, ex, er;
    r = '{mx: 0, sm: 0, fl: 0, ffv: 0, ffvec: 0};
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 4; a++) begin
        v  = b * 4 + a;
        ex = a * b;
        er = (ex > int'(l[v])) ? ex - int'(l[v]) : int'(l[v]) - ex;
        if (er > r.mx) r.mx = er;
        r.sm += er;
        if (er > 8) begin
          r.fl++;
          if (r.ffv == 0) begin
            r.ffv   = 1;
            r.ffvec = v;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_stim"}, 32'(o_stim), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_max"},  32'(o_max),  0);
    check({tag, "_sum"},  32'(o_sum),  0);
    check({tag, "_fcnt"}, 32'(o_fcnt), 0);
    check({tag, "_viol"}, 32'(o_viol), 0);
    check({tag, "_ffv"},  32'(o_ffv),  0);
  endtask

  task automatic set_start(input bit which, input logic v);
    if (which) start2 = v;
    else start0 = v;
  endtask

  task automatic sweep(input bit which, input int restart_at, input int rst_at,
                       input string tag);
    exp_t e;
    int   cyc;
    int   lat;
    sel = which;
    if (which) e = model(lut2);
    else e = model(lut0);
    lat = which ? 2 : 0;
    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    cyc = 0;
    check({tag, "_acc_sum"},  32'(o_sum),  0);
    check({tag, "_acc_max"},  32'(o_max),  0);
    check({tag, "_acc_fcnt"}, 32'(o_fcnt), 0);
    check({tag, "_acc_busy"}, 32'(o_busy), 1);
    check({tag, "_acc_done"}, 32'(o_done), 0);
    check({tag, "_acc_stim"}, 32'(o_stim), 0);
    while (!o_done && cyc < 60) begin
      set_start(which, cyc == restart_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_vals({tag, "_midrst"});
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 5) check({tag, "_stim5"}, 32'(o_stim), 5);
    end
    set_start(which, 1'b0);
    check({tag, "_latency"}, cyc, 16 + lat + 1);
    check({tag, "_busy"},    32'(o_busy), 0);
    check({tag, "_stim"},    32'(o_stim), 15);
    check({tag, "_max"},     32'(o_max),  e.mx);
    check({tag, "_sum"},     32'(o_sum),  e.sm);
    check({tag, "_fcnt"},    32'(o_fcnt), e.fl);
    check({tag, "_viol"},    32'(o_viol), (e.mx > 8) ? 1 : 0);
    check({tag, "_ffv"},     32'(o_ffv),   FF_EN ? e.ffv : 0);
    check({tag, "_ffvec"},   32'(o_ffvec), FF_EN ? e.ffvec : 0);
  endtask

  task automatic fill_exact(output lut_t l);
    for (int v = 0; v < 16; v++) l[v] = 4'((v % 4) * (v / 4));
  endtask

  task automatic fill_rand(output lut_t l);
    for (int v = 0; v < 16; v++) l[v] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    sel    = 1'b0;
    fill_exact(lut0);
    fill_exact(lut2);
    #12;
    check_reset_vals("reset0");
    sel = 1'b1;
    check_reset_vals("reset2");
    @(negedge clk);
    rst = 1'b0;

    sweep(1'b0, -1, -1, "exact");

    for (int v = 0; v < 16; v++) lut0[v] = 4'd0;
    sweep(1'b0, -1, -1, "zero");

    fill_exact(lut0);
    for (int v = 0; v < 16; v++) lut0[v] = lut0[v] ^ 4'd1;
    sweep(1'b0, -1, -1, "xor1");

    for (int v = 0; v < 16; v++) lut0[v] = 4'd0;
    sweep(1'b0, 5, -1, "restart");
    fill_exact(lut0);
    sweep(1'b0, -1, -1, "rerun");

    fill_rand(lut0);
    sweep(1'b0, -1, 8, "rst8");
    sweep(1'b0, -1, -1, "after_rst");

    for (int k = 0; k < 3; k++) begin
      fill_rand(lut0);
      sweep(1'b0, -1, -1, $sformatf("rand%0d", k));
    end

    sweep(1'b1, -1, -1, "lat2_exact");
    fill_rand(lut2);
    sweep(1'b1, -1, -1, "lat2_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
